// File: rtl/pri_icache_ctrl_slave_if.sv
// Private icache control bus between the cluster icache ctrl unit (master)
// and the cache-side responder (slave).
// Handshakes on this bus:
//  - bypass: level request. bypass_ack_o mirrors the bypass state actually
//    applied to the datapath, so the master waits until ack == req.
//  - flush : 4-phase. req rises; ack rises once every set is invalidated;
//    req falls; ack falls on the following cycle.
// Optional feature macro: ICACHE_CTRL_STALL_CNT_EN (adds ctrl_stall_count_o).
interface pri_icache_ctrl_slave_if #(
  parameter int unsigned CNT_W = 32
);
  logic             bypass_req_i;
  logic             bypass_ack_o;
  logic             flush_req_i;
  logic             flush_ack_o;
  logic             ctrl_clear_regs_i;
  logic             ctrl_enable_regs_i;
  logic [CNT_W-1:0] ctrl_hit_count_o;
  logic [CNT_W-1:0] ctrl_trans_count_o;
  logic [CNT_W-1:0] ctrl_miss_count_o;
`ifdef ICACHE_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] ctrl_stall_count_o;
`endif

  modport master (
    output bypass_req_i, flush_req_i, ctrl_clear_regs_i, ctrl_enable_regs_i,
`ifdef ICACHE_CTRL_STALL_CNT_EN
    input  ctrl_stall_count_o,
`endif
    input  bypass_ack_o, flush_ack_o,
    input  ctrl_hit_count_o, ctrl_trans_count_o, ctrl_miss_count_o
  );

  modport slave (
    input  bypass_req_i, flush_req_i, ctrl_clear_regs_i, ctrl_enable_regs_i,
`ifdef ICACHE_CTRL_STALL_CNT_EN
    output ctrl_stall_count_o,
`endif
    output bypass_ack_o, flush_ack_o,
    output ctrl_hit_count_o, ctrl_trans_count_o, ctrl_miss_count_o
  );
endinterface

// File: rtl/pri_icache_ctrl_slave.sv
// Cache-side responder of the private icache control bus.
//  - Applies bypass changes once the cache has drained (fetch hold meanwhile).
//  - Serves flushes by walking every set through the tag invalidation port.
//  - Keeps saturating hit / transaction / miss statistics counters.
// Optional feature macro: ICACHE_CTRL_STALL_CNT_EN adds a saturating counter
// of fetch-hold cycles on ctrl.ctrl_stall_count_o.
module pri_icache_ctrl_slave #(
  parameter  int unsigned NB_SETS = 64,
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned SET_W   = $clog2(NB_SETS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  pri_icache_ctrl_slave_if.slave ctrl,
  input  logic                   evt_trans_i,
  input  logic                   evt_hit_i,
  input  logic                   evt_miss_i,
  input  logic                   cache_idle_i,
  output logic                   fetch_hold_o,
  output logic                   bypass_en_o,
  output logic                   tag_inv_req_o,
  output logic [SET_W-1:0]       tag_inv_set_o,
  input  logic                   tag_inv_gnt_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN_BYP = 3'd1,
    DRAIN_FL  = 3'd2,
    FLUSH     = 3'd3,
    FL_ACK    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             bypass_q, bypass_d;
  logic [SET_W-1:0] set_q, set_d;

  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] trans_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // Clear beats a same-cycle event; counting stops at all-ones.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] q,
                                                input logic clr,
                                                input logic en,
                                                input logic ev);
    logic [CNT_W-1:0] r;
    r = q;
    if (clr) begin
      r = '0;
    end else if (en && ev && (q != {CNT_W{1'b1}})) begin
      r = q + CNT_W'(1);
    end
    return r;
  endfunction

  // Control state, applied bypass and flush set pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bypass_q <= 1'b0;
      set_q    <= '0;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
      set_q    <= set_d;
    end
  end

  // Next-state logic; a flush request wins over a pending bypass change.
  always_comb begin
    state_d  = state_q;
    bypass_d = bypass_q;
    set_d    = set_q;
    case (state_q)
      IDLE: begin
        // flush_ack_o is low in IDLE, so a high request is always a new flush.
        if (ctrl.flush_req_i) begin
          state_d = DRAIN_FL;
        end else if (ctrl.bypass_req_i != bypass_q) begin
          state_d = DRAIN_BYP;
        end
      end
      DRAIN_BYP: begin
        if (cache_idle_i) begin
          bypass_d = ctrl.bypass_req_i;
          state_d  = IDLE;
        end
      end
      DRAIN_FL: begin
        if (cache_idle_i) begin
          set_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (tag_inv_gnt_i) begin
          // Power-of-2 set count: the increment wraps back to 0 after the last set.
          set_d = set_q + SET_W'(1);
          if (set_q == SET_W'(NB_SETS - 1)) begin
            state_d = FL_ACK;
          end
        end
      end
      FL_ACK: begin
        if (!ctrl.flush_req_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fetch_hold_o      = (state_q == DRAIN_BYP) || (state_q == DRAIN_FL) || (state_q == FLUSH);
  assign tag_inv_req_o     = (state_q == FLUSH);
  assign tag_inv_set_o     = set_q;
  assign bypass_en_o       = bypass_q;
  assign ctrl.bypass_ack_o = bypass_q;
  assign ctrl.flush_ack_o  = (state_q == FL_ACK);

  // Statistics counters, one independent saturating counter per event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q   <= '0;
      trans_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      hit_cnt_q   <= cnt_next(hit_cnt_q, ctrl.ctrl_clear_regs_i, ctrl.ctrl_enable_regs_i, evt_hit_i);
      trans_cnt_q <= cnt_next(trans_cnt_q, ctrl.ctrl_clear_regs_i, ctrl.ctrl_enable_regs_i, evt_trans_i);
      miss_cnt_q  <= cnt_next(miss_cnt_q, ctrl.ctrl_clear_regs_i, ctrl.ctrl_enable_regs_i, evt_miss_i);
    end
  end

  assign ctrl.ctrl_hit_count_o   = hit_cnt_q;
  assign ctrl.ctrl_trans_count_o = trans_cnt_q;
  assign ctrl.ctrl_miss_count_o  = miss_cnt_q;

`ifdef ICACHE_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Counts cycles in which new fetches are held off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= cnt_next(stall_cnt_q, ctrl.ctrl_clear_regs_i, ctrl.ctrl_enable_regs_i, fetch_hold_o);
    end
  end

  assign ctrl.ctrl_stall_count_o = stall_cnt_q;
`endif

endmodule
